// File: rtl/oclib_csr_regbank_if.sv
// rtl/oclib_csr_regbank_if.sv - CSR request/response structs and the bus interface of the register bank
package oclib_pkg;

  typedef struct packed {
    logic [31:0] address;
    logic        write;
    logic        read;
    logic [31:0] wdata;
  } csr_32_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } csr_32_fb_s;

endpackage

interface oclib_csr_regbank_if #(
  parameter type CsrType   = oclib_pkg::csr_32_s,
  parameter type CsrFbType = oclib_pkg::csr_32_fb_s
);
  logic     csrSelect;
  CsrType   csr;
  CsrFbType csrFb;

  modport master (output csrSelect, output csr, input csrFb);
  modport slave  (input csrSelect, input csr, output csrFb);
endinterface

// File: rtl/oclib_csr_regbank.sv
// rtl/oclib_csr_regbank.sv - CSR register bank with one-shot response FSM; OCLIB_CSR_REGBANK_ERROR_EN enables error responses
module oclib_csr_regbank #(
  parameter type                   CsrType      = oclib_pkg::csr_32_s,
  parameter type                   CsrFbType    = oclib_pkg::csr_32_fb_s,
  parameter int                    NumRegs      = 8,
  parameter logic [NumRegs-1:0]    ReadOnlyMask = '0,
  parameter logic [NumRegs*32-1:0] ResetValue   = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  oclib_csr_regbank_if.slave        bus,
  output logic [NumRegs*32-1:0]     regOut,
  input  logic [NumRegs*32-1:0]     regIn,
  output logic [NumRegs-1:0]        regWritePulse
);

  localparam int IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  // Read-only slots never hold data, so they come out of reset as zero.
  function automatic logic [NumRegs*32-1:0] reset_image();
    logic [NumRegs*32-1:0] img;
    img = ResetValue;
    for (int i = 0; i < NumRegs; i++) begin
      if (ReadOnlyMask[i]) img[i*32 +: 32] = 32'h0;
    end
    return img;
  endfunction

  localparam logic [NumRegs*32-1:0] RstImage = reset_image();

  typedef enum logic [1:0] {Idle, Respond, Release} state_e;

  state_e                 state_q, state_d;
  CsrType                 req;
  CsrFbType               fb;
  logic [1:0]             rst_sync_q;
  logic                   rst_n_int;
  logic                   req_valid;
  logic [IdxW-1:0]        req_idx;
  logic                   valid_q;
  logic                   write_q;
  logic [IdxW-1:0]        idx_q;
  logic [31:0]            wdata_q;
  logic [NumRegs*32-1:0]  regs_q;
  logic [NumRegs-1:0]     pulse_q;
  logic                   ready_q;
  logic [31:0]            rdata_q;
  logic                   ro_hit;
  logic                   wr_ok;
  logic                   rd_ok;
`ifdef OCLIB_CSR_REGBANK_ERROR_EN
  logic                   error_q;
`endif

  assign req           = bus.csr;
  assign regOut        = regs_q;
  assign regWritePulse = pulse_q;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  // Decode the live request: aligned, in range, exactly one of read/write.
  always_comb begin
    req_valid = (req.address[1:0] == 2'b00) &&
                ({2'b00, req.address[31:2]} < 32'(NumRegs)) &&
                (req.read ^ req.write);
    req_idx   = req.address[IdxW+1:2];
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) state_q <= Idle;
    else            state_q <= state_d;
  end

  // FSM next state: serve once, then wait for the requester to let go.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle:    if (bus.csrSelect && (req.read || req.write)) state_d = Respond;
      Respond: state_d = Release;
      Release: if (!req.read && !req.write) state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  // Latch the request while idle so the response uses what was seen at acceptance.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (state_q == Idle) begin
      valid_q <= req_valid;
      write_q <= req.write;
      idx_q   <= req_idx;
      wdata_q <= req.wdata;
    end
  end

  // Classify the captured access for the response cycle.
  always_comb begin
    ro_hit = ReadOnlyMask[idx_q];
    wr_ok  = (state_q == Respond) && valid_q && write_q && !ro_hit;
    rd_ok  = valid_q && !write_q;
  end

  // Register file and write strobes; updates land on the same edge as ready.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      regs_q  <= RstImage;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (wr_ok) begin
        regs_q[{idx_q, 5'b00000} +: 32] <= wdata_q;
        pulse_q[idx_q]                  <= 1'b1;
      end
    end
  end

  // One-cycle response pulse; rdata holds until the next response.
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
`ifdef OCLIB_CSR_REGBANK_ERROR_EN
      error_q <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef OCLIB_CSR_REGBANK_ERROR_EN
      error_q <= 1'b0;
`endif
      if (state_q == Respond) begin
        if (wr_ok) begin
          ready_q <= 1'b1;
          rdata_q <= '0;
        end else if (rd_ok) begin
          ready_q <= 1'b1;
          rdata_q <= ro_hit ? regIn[{idx_q, 5'b00000} +: 32] : regs_q[{idx_q, 5'b00000} +: 32];
        end else begin
`ifdef OCLIB_CSR_REGBANK_ERROR_EN
          error_q <= 1'b1;
`else
          ready_q <= 1'b1;
`endif
          rdata_q <= '0;
        end
      end
    end
  end

  // Pack the response struct.
  always_comb begin
    fb       = '0;
    fb.ready = ready_q;
    fb.rdata = rdata_q;
`ifdef OCLIB_CSR_REGBANK_ERROR_EN
    fb.error = error_q;
`else
    fb.error = 1'b0;
`endif
  end

  assign bus.csrFb = fb;

endmodule

// File: tb/tb_oclib_csr_regbank.sv
// tb/tb_oclib_csr_regbank.sv - directed bench with a per-cycle reference model for oclib_csr_regbank
module tb_oclib_csr_regbank;

  localparam int              N      = 8;
  localparam logic [N-1:0]    RoMask = 8'h20;
  localparam logic [N*32-1:0] RstVal = {32'h8888_0008, 32'h7777_0007, 32'h6666_0006, 32'h5555_0005,
                                        32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
`ifdef OCLIB_CSR_REGBANK_ERROR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*32-1:0] reg_out;
  logic [N*32-1:0] reg_in;
  logic [N-1:0]    wpulse;

  oclib_csr_regbank_if bus ();

  oclib_csr_regbank #(
    .NumRegs      (N),
    .ReadOnlyMask (RoMask),
    .ResetValue   (RstVal)
  ) dut (
    .clock         (clk),
    .reset         (rst_n),
    .bus           (bus),
    .regOut        (reg_out),
    .regIn         (reg_in),
    .regWritePulse (wpulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b1;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int pulse_cnt = 0;
  logic [N-1:0] last_pulse = '0;

  logic [31:0]     m_regs [N];
  logic            m_ready;
  logic            m_error;
  logic [31:0]     m_rdata;
  bit              m_rdata_known;
  logic [N-1:0]    m_pulse;
  logic [N*32-1:0] exp_out;

  task automatic fail(input string name, input logic [255:0] act, input logic [255:0] req);
    $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    n_err++;
  endtask

  task automatic check_lit(input string name, input logic [255:0] act, input logic [255:0] req);
    n_vec++;
    if (act !== req) fail(name, act, req);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = RoMask[i] ? 32'h0 : RstVal[i*32 +: 32];
    m_ready       = 1'b0;
    m_error       = 1'b0;
    m_rdata       = 32'h0;
    m_rdata_known = 1'b1;
    m_pulse       = '0;
  endtask

  // What the response cycle must look like, straight from the access rules.
  task automatic model_respond(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    int idx;
    bit valid;
    idx   = int'(addr >> 2);
    valid = (addr[1:0] == 2'b00) && (addr < 32'(N*4)) && (rd != wr);
    if (valid && wr && !RoMask[idx]) begin
      m_regs[idx]   = wdata;
      m_pulse       = '0;
      m_pulse[idx]  = 1'b1;
      m_ready       = 1'b1;
      m_rdata_known = 1'b0;
    end else if (valid && rd) begin
      m_ready       = 1'b1;
      m_rdata       = RoMask[idx] ? reg_in[idx*32 +: 32] : m_regs[idx];
      m_rdata_known = 1'b1;
    end else if (ErrEn) begin
      m_error       = 1'b1;
      m_rdata       = 32'h0;
      m_rdata_known = 1'b1;
    end else begin
      m_ready = 1'b1;
      if (rd && !wr) begin
        m_rdata       = 32'h0;
        m_rdata_known = 1'b1;
      end else begin
        m_rdata_known = 1'b0;
      end
    end
  endtask

  task automatic model_quiet();
    m_ready = 1'b0;
    m_error = 1'b0;
    m_pulse = '0;
  endtask

  task automatic drop_req();
    bus.csrSelect = 1'b0;
    bus.csr.read  = 1'b0;
    bus.csr.write = 1'b0;
  endtask

  // Request accepted at edge N responds at edge N+1; the request is released one cycle after the pulse.
  task automatic xact(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int extra_hold);
    @(posedge clk); #1;
    bus.csrSelect   = sel;
    bus.csr.read    = rd;
    bus.csr.write   = wr;
    bus.csr.address = addr;
    bus.csr.wdata   = wdata;
    if (sel && (rd || wr)) begin
      @(posedge clk);
      @(posedge clk); #1;
      model_respond(rd, wr, addr, wdata);
      @(posedge clk); #1;
      model_quiet();
    end else begin
      repeat (3) @(posedge clk);
      #1;
    end
    if (extra_hold > 0) begin
      repeat (extra_hold) @(posedge clk);
      #1;
    end
    drop_req();
  endtask

  // Compare process: every cycle against the model, plus independent pulse counters.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      for (int i = 0; i < N; i++) exp_out[i*32 +: 32] = m_regs[i];
      if (bus.csrFb.ready !== m_ready) fail("ready", 256'(bus.csrFb.ready), 256'(m_ready));
      if (bus.csrFb.error !== m_error) fail("error", 256'(bus.csrFb.error), 256'(m_error));
      if (m_rdata_known && (bus.csrFb.rdata !== m_rdata)) fail("rdata", 256'(bus.csrFb.rdata), 256'(m_rdata));
      if (wpulse !== m_pulse) fail("regWritePulse", 256'(wpulse), 256'(m_pulse));
      if (reg_out !== exp_out) fail("regOut", 256'(reg_out), 256'(exp_out));
    end
    if (bus.csrFb.ready === 1'b1) rdy_cnt++;
    if (bus.csrFb.error === 1'b1) err_cnt++;
    if (wpulse != '0) begin
      pulse_cnt++;
      last_pulse = wpulse;
    end
  end

  initial begin
    bus.csrSelect = 1'b0;
    bus.csr       = '0;
    for (int i = 0; i < N; i++) reg_in[i*32 +: 32] = 32'hF0F0_0000 | 32'(i);
    reg_in[5*32 +: 32] = 32'h1234_5678;
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check_lit("rst_reg0", 256'(reg_out[31:0]), 256'(32'h1111_0001));
    check_lit("rst_reg5_ro", 256'(reg_out[191:160]), 256'(32'h0));
    check_lit("rst_ready", 256'(bus.csrFb.ready), 256'(1'b0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    rdy_cnt = 0; pulse_cnt = 0;
    xact(1'b1, 1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF, 0);
    check_lit("wr_reg2_value", 256'(reg_out[95:64]), 256'(32'hDEAD_BEEF));
    check_lit("wr_reg2_pulse", 256'(last_pulse), 256'(8'h04));
    check_lit("wr_reg2_pulse_cnt", 256'(pulse_cnt), 256'(1));
    check_lit("wr_reg2_ready_cnt", 256'(rdy_cnt), 256'(1));
    xact(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 0);
    check_lit("rd_reg2", 256'(bus.csrFb.rdata), 256'(32'hDEAD_BEEF));

    xact(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 0);
    check_lit("rd_ro5", 256'(bus.csrFb.rdata), 256'(32'h1234_5678));
    rdy_cnt = 0; err_cnt = 0; pulse_cnt = 0;
    xact(1'b1, 1'b0, 1'b1, 32'h14, 32'hFFFF_FFFF, 0);
    check_lit("wr_ro5_no_pulse", 256'(pulse_cnt), 256'(0));
    check_lit("wr_ro5_regout", 256'(reg_out[191:160]), 256'(32'h0));
    check_lit("wr_ro5_resp_cnt", 256'(ErrEn ? err_cnt : rdy_cnt), 256'(1));

    xact(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 0);
    check_lit("rd_out_of_range", 256'(bus.csrFb.rdata), 256'(32'h0));
    xact(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 0);
    xact(1'b1, 1'b1, 1'b0, 32'h6, 32'h0, 0);
    check_lit("rd_unaligned", 256'(bus.csrFb.rdata), 256'(32'h0));

    xact(1'b1, 1'b0, 1'b1, 32'h1C, 32'h0BAD_F00D, 0);
    xact(1'b1, 1'b0, 1'b1, 32'h0, 32'h5A5A_5A5A, 0);
    xact(1'b1, 1'b1, 1'b0, 32'h1C, 32'h0, 0);
    check_lit("rd_reg7", 256'(bus.csrFb.rdata), 256'(32'h0BAD_F00D));
    xact(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 0);
    xact(1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 0);
    check_lit("rdwr_both_unchanged", 256'(reg_out[31:0]), 256'(32'h5A5A_5A5A));

    rdy_cnt = 0;
    xact(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 8);
    check_lit("held_read_one_pulse", 256'(rdy_cnt), 256'(1));
    xact(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 0);
    check_lit("reassert_second_pulse", 256'(rdy_cnt), 256'(2));
    xact(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4);
    check_lit("no_select_no_pulse", 256'(rdy_cnt), 256'(2));

    @(posedge clk); #1;
    bus.csrSelect   = 1'b1;
    bus.csr.read    = 1'b0;
    bus.csr.write   = 1'b1;
    bus.csr.address = 32'h0;
    bus.csr.wdata   = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_lit("rst_abort_ready", 256'(bus.csrFb.ready), 256'(1'b0));
    check_lit("rst_abort_pulse", 256'(wpulse), 256'(8'h00));
    check_lit("rst_abort_reg0", 256'(reg_out[31:0]), 256'(32'h1111_0001));
    repeat (2) @(posedge clk); #1;
    chk_en = 1'b0;
    rdy_cnt = 0; pulse_cnt = 0;
    rst_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    check_lit("post_rst_ready_cnt", 256'(rdy_cnt), 256'(1));
    check_lit("post_rst_pulse_cnt", 256'(pulse_cnt), 256'(1));
    check_lit("post_rst_reg0", 256'(reg_out[31:0]), 256'(32'hCAFE_F00D));
    drop_req();
    m_regs[0]     = 32'hCAFE_F00D;
    m_rdata_known = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    xact(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 0);
    check_lit("rd_reg0_after_rst", 256'(bus.csrFb.rdata), 256'(32'hCAFE_F00D));
    xact(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 0);
    check_lit("rd_reg2_after_rst", 256'(bus.csrFb.rdata), 256'(32'h3333_0003));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oclib_csr_regbank.md
OCLIB_CSR_REGBANK -- requirements
Module: oclib_csr_regbank

Interface
REQ-001 SHALL have parameter: CsrType, default oclib_pkg::csr_32_s, request struct type (address, write, read, wdata).
REQ-002 SHALL have parameter: CsrFbType, default oclib_pkg::csr_32_fb_s, response struct type (rdata, ready, error).
REQ-003 SHALL have parameter: NumRegs, default 8, register count (1..64).
REQ-004 SHALL have parameter: ReadOnlyMask, default '0 (NumRegs bits), where bit i=1 makes register i a read-only status register.
REQ-005 SHALL have parameter: ResetValue, default '0 (NumRegs*32 bits), the reset value of each writable register.
REQ-006 SHALL have port: clock  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port: csrSelect  input  1  request qualifier; requests are ignored while low.
REQ-009 SHALL have port: csr  input  CsrType  level request, held until the response pulse is seen.
REQ-010 SHALL have port: csrFb  output  CsrFbType  response: one-cycle ready/error pulse plus rdata.
REQ-011 SHALL have port: regOut  output  NumRegs*32  current contents of the writable registers.
REQ-012 SHALL have port: regIn  input  NumRegs*32  status values returned on reads of read-only registers.
REQ-013 SHALL have port: regWritePulse  output  NumRegs  one-cycle strobe when register i is written.

Function
REQ-014 SHALL decode index = address>>2; an access SHALL be valid only when address[1:0]==0, index<NumRegs, and exactly one of read/write is high.
REQ-015 SHALL implement states: Idle, Respond, Release.
REQ-016 Idle: SHALL move to Respond when csrSelect && (read||write), capturing index, wdata, and the access kind.
REQ-017 Respond: SHALL drive exactly one cycle of ready (valid access) or error (invalid, when enabled per REQ-027), then move to Release.
REQ-018 Release: SHALL return to Idle only when read and write are both low; a request still held SHALL NOT be re-served.
REQ-019 Latency SHALL be: request seen in Idle at edge N -> response pulse and write update at edge N+1.
REQ-020 A valid write to a writable register SHALL update regOut and pulse regWritePulse[index] in the same cycle as ready.
REQ-021 A valid read SHALL return regOut[index] for writable registers and regIn[index] for read-only registers; rdata SHALL be registered with ready and held until the next response.
REQ-022 A write to a read-only register SHALL leave state unchanged and SHALL NOT pulse regWritePulse.
REQ-023 Ready and error SHALL never be high in the same cycle; at most one regWritePulse bit SHALL be high at a time.

Reset
REQ-024 Reset low SHALL immediately force: state Idle, csrFb all zero, regWritePulse zero, regOut=ResetValue (read-only slots 0).
REQ-025 A reset asserted mid-transaction SHALL abort it with no response pulse; after release, a still-held request SHALL be served as new.
REQ-026 Reset release SHALL be synchronized internally to clock before use.

Configuration
REQ-027 With OCLIB_CSR_REGBANK_ERROR_EN defined, an invalid access or a write to a read-only register SHALL respond with error=1, ready=0, rdata=0.
REQ-028 Without OCLIB_CSR_REGBANK_ERROR_EN, such accesses SHALL respond with ready=1, error=0, and rdata=0 on reads; writes SHALL be ignored; csrFb.error SHALL be tied 0.

Verification
REQ-029 Write 0xDEADBEEF to address 0x8 (reg 2 writable) -> ready pulse 1 cycle at N+1, regOut[2]=0xDEADBEEF, regWritePulse=0x04 for 1 cycle; read 0x8 -> rdata=0xDEADBEEF.
REQ-030 ReadOnlyMask bit 5, regIn[5]=0x12345678: read 0x14 -> rdata 0x12345678; write 0x14 -> no regOut/pulse change; error=1 with ERROR_EN, ready=1 without.
REQ-031 Read address 0x20 with NumRegs=8, and read address 0x6 -> error (ERROR_EN) or ready with rdata 0 (no macro).
REQ-032 Hold read high 10 cycles -> exactly one ready pulse; drop for 1 cycle, reassert -> second pulse; csrSelect=0 with read high -> no pulse.
REQ-033 Assert reset during Respond after a write to reg 0 -> no pulse, regOut[0]=ResetValue[0]; after release with request held -> single new response.
REQ-034 Read and write both high at 0x0 -> treated as invalid per REQ-027/028, regOut unchanged.
